// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_OPCHK_EN blocks reserved opcodes (2'b10/2'b11) and flags them on rsp_err.
module alu_arb_ctrl #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_r,
  input  logic         alu_flag,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r,
  output logic         rsp_flag,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       r_state;
  logic         r_ptr;
  logic         r_id;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [1:0]   r_op;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_rsp_valid;
  logic [W-1:0] r_rsp_r;
  logic         r_rsp_flag;

  logic         w_pick1;
  logic         w_bad;

  // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
  assign w_pick1 = req1 & (~req0 | r_ptr);

`ifdef ALU_ARB_OPCHK_EN
  logic r_rsp_err;
  assign w_bad   = r_op[1];
  assign rsp_err = r_rsp_err;
`else
  assign w_bad   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_flag  <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            r_id    <= w_pick1;
            r_a     <= w_pick1 ? a1  : a0;
            r_b     <= w_pick1 ? b1  : b0;
            r_op    <= w_pick1 ? op1 : op0;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // A blocked opcode never reached the ALU, so its result is forced to zero.
          r_rsp_r     <= w_bad ? '0 : alu_r;
          r_rsp_flag  <= w_bad ? 1'b0 : alu_flag;
`ifdef ALU_ARB_OPCHK_EN
          r_rsp_err   <= w_bad;
`endif
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= ~r_id;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign alu_a     = (r_state == EXEC) ? r_a : '0;
  assign alu_b     = (r_state == EXEC) ? r_b : '0;
  assign alu_op    = (r_state == EXEC && !w_bad) ? r_op : 2'b11;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_flag  = r_rsp_flag;
  assign busy      = (r_state != IDLE);

endmodule
